alu_seq: RTL
============

Name: alu_seq

Overview:
Parametrised successor to the single-cycle 6502/65Org16 ALU. It keeps the add, subtract, logic and shift/rotate operations, and adds iterative unsigned multiply and divide. Operations are launched with a start/done handshake, and RDY stalls every register. It sits in the CPU datapath beside the register file; the control FSM launches an operation and waits for done.

Parameters:
dw, 16, data width (8 for 6502, 16 for 65Org16, any even value >= 8)
sw, 4, shift-amount width; must satisfy 2**sw >= dw

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high
RDY  input  1  global stall; when low, every register holds its value
start  input  1  launch op; sampled only when not busy and RDY=1
op  input  4  operation select (see Behaviour)
right  input  1  shift direction for the SHF op (1=right)
rotate  input  1  SHF rotates when 1; otherwise shifts (arithmetic when right)
AI  input  dw  operand A / dividend / multiplicand
BI  input  dw  operand B / divisor / multiplier
EI  input  sw  shift amount for SHF
CI  input  1  carry in
OUT  output  dw  result low: sum, logic, shifted value, product[dw-1:0], quotient
HI  output  dw  product[2dw-1:dw] or remainder; 0 for other ops
CO  output  1  carry out
V  output  1  overflow
Z  output  1  OUT==0
N  output  1  OUT[dw-1]
busy  output  1  multi-cycle op in progress
done  output  1  one-cycle pulse: outputs valid
dbz  output  1  divide by zero flagged on last DIV

Behaviour:
- Op encoding:
  - 0011 A+B+CI
  - 0111 A-B (A+~B+CI)
  - 1011 A+A+CI
  - 1100 OR; 1101 AND; 1110 XOR; 1111 pass A
  - 0010 SHF; 0000 MUL; 0001 DIV
  - Other codes: treated as pass A
- Reset: OUT=0, HI=0, CO=0, V=0, N=0, Z=1, busy=0, done=0, dbz=0, FSM=IDLE, counter=0. Reset wins over RDY and start.
- FSM states: IDLE, MUL, DIV, FIN.
  - IDLE: start with a single-cycle op (including DIV by zero) registers the result and flags on the same edge; done=1 the next cycle. Latency 1.
  - IDLE: start with MUL or DIV (BI!=0) latches operands, clears the counter, sets busy=1, and enters MUL or DIV.
  - MUL: shift-add, one multiplier bit per cycle, LSB first.
  - DIV: restoring division, one quotient bit per cycle, MSB first.
  - Counter reaches dw-1 -> FIN.
  - FIN: write OUT/HI and flags, busy=0, done=1, return to IDLE.
  - MUL/DIV latency: done is high exactly dw+1 RDY-enabled cycles after the start cycle.
- start while busy: ignored; operand changes while busy have no effect.
- start in the same cycle done is high: accepted (back-to-back).
- RDY=0: FSM, counter, outputs and done all hold. A done pulse held by RDY=0 lasts until the next RDY=1 cycle.
- Arithmetic flags:
  - CO = bit dw of the sum.
  - V = (A[dw-1]==B'[dw-1]) && (OUT[dw-1]!=A[dw-1]), where B' is the effective second addend.
- Logic ops and pass: CO=0, V=0.
- SHF:
  - Amount EI mod 2**sw. EI=0 gives OUT=AI, CO=CI.
  - Left: vacated bits 0 unless rotate; rotate is through CI, dw+1 bits.
  - Right: vacated bits = AI[dw-1] unless rotate; rotate is through CI.
  - CO = last bit shifted out. V=0.
- MUL: {HI,OUT} = AI*BI, 2dw bits; V = |HI; CO=0.
- DIV:
  - BI!=0: OUT=AI/BI, HI=AI%BI, dbz=0, V=0, CO=0.
  - BI==0: single cycle; OUT=all ones, HI=AI, dbz=1, V=1.
- Z and N are always derived from the registered OUT. dbz updates only on DIV completion.
- Reset mid-operation: aborts; the next cycle matches post-reset state and no done pulse is emitted.

Optional Feature:
ALU_SIGNED_EN
- Defined:
  - op 1000 = signed MUL, op 1001 = signed DIV (two's complement).
  - Operands are converted to magnitude on entry; the result sign is corrected in an extra SGN state after FIN. Latency dw+2.
  - Remainder takes the dividend's sign; quotient truncates toward zero.
  - Signed MUL: V=1 when HI is not the sign-extension of OUT[dw-1].
  - Signed DIV: dividend=most negative, divisor=-1 gives OUT=most negative, HI=0, V=1.
- Undefined: 1000/1001 are treated as pass A; no SGN state.

Test Plan:
- dw=16: start, op=0011, AI=FFFF, BI=0001, CI=0 -> next cycle done=1, OUT=0000, CO=1, Z=1, V=0.
- op=0000, AI=1234, BI=0010 -> busy for 16 cycles, done at start+17, OUT=2340, HI=0001, V=1.
- op=0001, AI=03E8, BI=0007 -> done at start+17, OUT=008E, HI=0006, dbz=0. Then BI=0000 -> done at +1, OUT=FFFF, HI=03E8, dbz=1.
- op=0010, right=1, rotate=0, AI=8001, EI=4 -> OUT=F800, CO=0. right=0, rotate=1, CI=1, EI=1 -> OUT=0003, CO=1.
- MUL in progress; RDY=0 for 5 cycles at cycle 8 -> done delayed exactly 5 cycles, result unchanged. A start pulse while busy is ignored.
- reset=1 at cycle 6 of a DIV -> busy=0, done=0, OUT=0, Z=1 next cycle. A new ADD then completes normally.

Source files
------------

// File: rtl/alu_seq.sv
// Sequential ALU: add/sub/logic/shift in one cycle, iterative unsigned MUL and DIV (signed with ALU_SIGNED_EN).
// Latency: 1 cycle for single-cycle ops and DIV by zero, dw+1 for MUL/DIV, dw+2 for signed MUL/DIV.
// Backpressure: RDY=0 freezes every register, including a pending done pulse; start is ignored while busy.
module alu_seq #(
    parameter int dw = 16,
    parameter int sw = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          RDY,
    input  logic          start,
    input  logic [3:0]    op,
    input  logic          right,
    input  logic          rotate,
    input  logic [dw-1:0] AI,
    input  logic [dw-1:0] BI,
    input  logic [sw-1:0] EI,
    input  logic          CI,
    output logic [dw-1:0] OUT,
    output logic [dw-1:0] HI,
    output logic          CO,
    output logic          V,
    output logic          Z,
    output logic          N,
    output logic          busy,
    output logic          done,
    output logic          dbz
);

    localparam int CW = (dw > 1) ? $clog2(dw) : 1;

`ifdef ALU_SIGNED_EN
    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIN, S_SGN} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;
`endif

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [dw-1:0]   a_q, a_d;
    logic [2*dw-1:0] acc_q, acc_d;
    logic [dw-1:0]   out_q, out_d;
    logic [dw-1:0]   hi_q, hi_d;
    logic            co_q, co_d;
    logic            v_q, v_d;
    logic            dbz_q, dbz_d;
    logic            done_q, done_d;
    logic            accept;
    logic            last;
    logic            sgn_pend;

    logic [dw-1:0]   bp;
    logic [dw:0]     sum;
    logic            add_v;
    logic [dw-1:0]   sh_v;
    logic            sh_c;
    logic            c_new;
    logic [dw-1:0]   sc_out;
    logic            sc_co;
    logic            sc_v;

    logic [dw:0]     mul_sum;
    logic [2*dw-1:0] mul_nxt;
    logic [dw:0]     trial;
    logic [dw:0]     diff;
    logic [2*dw-1:0] div_nxt;

`ifdef ALU_SIGNED_EN
    logic            sop_q, sop_d;
    logic            sdiv_q, sdiv_d;
    logic            qneg_q, qneg_d;
    logic            rneg_q, rneg_d;
    logic [dw-1:0]   sq, sr;
    logic [2*dw-1:0] sp;

    function automatic logic [dw-1:0] mag(input logic [dw-1:0] x);
        return x[dw-1] ? -x : x;
    endfunction

    assign sq       = qneg_q ? -acc_q[dw-1:0] : acc_q[dw-1:0];
    assign sr       = rneg_q ? -acc_q[2*dw-1:dw] : acc_q[2*dw-1:dw];
    assign sp       = qneg_q ? -acc_q : acc_q;
    assign sgn_pend = sop_q;
`else
    assign sgn_pend = 1'b0;
`endif

    assign last = (cnt_q == CW'(dw - 1));

    // One multiplier bit per step: add multiplicand into the high half, then shift the pair right.
    assign mul_sum = {1'b0, acc_q[2*dw-1:dw]} + (acc_q[0] ? {1'b0, a_q} : {(dw+1){1'b0}});
    assign mul_nxt = {mul_sum, acc_q[dw-1:1]};

    // Restoring step: partial remainder and quotient share acc_q, quotient bits enter at the bottom.
    assign trial   = acc_q[2*dw-1:dw-1];
    assign diff    = trial - {1'b0, a_q};
    assign div_nxt = diff[dw] ? {trial[dw-1:0], acc_q[dw-2:0], 1'b0}
                              : {diff[dw-1:0], acc_q[dw-2:0], 1'b1};

    always_comb begin
        bp = BI;
        case (op)
            4'b0111: bp = ~BI;
            4'b1011: bp = AI;
            default: bp = BI;
        endcase
        sum   = {1'b0, AI} + {1'b0, bp} + {{dw{1'b0}}, CI};
        add_v = (AI[dw-1] == bp[dw-1]) && (sum[dw-1] != AI[dw-1]);

        sh_v  = AI;
        sh_c  = CI;
        c_new = CI;
        for (int k = 0; k < 2**sw; k++) begin
            if (k < int'(EI)) begin
                if (right) begin
                    c_new = sh_v[0];
                    sh_v  = {(rotate ? sh_c : sh_v[dw-1]), sh_v[dw-1:1]};
                end else begin
                    c_new = sh_v[dw-1];
                    sh_v  = {sh_v[dw-2:0], rotate & sh_c};
                end
                sh_c = c_new;
            end
        end

        sc_out = AI;
        sc_co  = 1'b0;
        sc_v   = 1'b0;
        case (op)
            4'b0011, 4'b0111, 4'b1011: begin
                sc_out = sum[dw-1:0];
                sc_co  = sum[dw];
                sc_v   = add_v;
            end
            4'b1100: sc_out = AI | BI;
            4'b1101: sc_out = AI & BI;
            4'b1110: sc_out = AI ^ BI;
            4'b0010: begin
                sc_out = sh_v;
                sc_co  = sh_c;
            end
            default: sc_out = AI;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        acc_d   = acc_q;
        out_d   = out_q;
        hi_d    = hi_q;
        co_d    = co_q;
        v_d     = v_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;
        accept  = 1'b0;
`ifdef ALU_SIGNED_EN
        sop_d   = sop_q;
        sdiv_d  = sdiv_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
`endif

        case (state_q)
            S_IDLE: accept = 1'b1;
            S_MUL: begin
                acc_d = mul_nxt;
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    state_d = S_FIN;
                    if (!sgn_pend) begin
                        out_d  = mul_nxt[dw-1:0];
                        hi_d   = mul_nxt[2*dw-1:dw];
                        co_d   = 1'b0;
                        v_d    = |mul_nxt[2*dw-1:dw];
                        done_d = 1'b1;
                    end
                end
            end
            S_DIV: begin
                acc_d = div_nxt;
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    state_d = S_FIN;
                    if (!sgn_pend) begin
                        out_d  = div_nxt[dw-1:0];
                        hi_d   = div_nxt[2*dw-1:dw];
                        co_d   = 1'b0;
                        v_d    = 1'b0;
                        dbz_d  = 1'b0;
                        done_d = 1'b1;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
`ifdef ALU_SIGNED_EN
                // Signed ops spend FIN applying the sign; the result is presented from SGN.
                if (sop_q) begin
                    co_d    = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_SGN;
                    if (sdiv_q) begin
                        out_d = sq;
                        hi_d  = sr;
                        v_d   = acc_q[dw-1] & ~qneg_q;
                        dbz_d = 1'b0;
                    end else begin
                        out_d = sp[dw-1:0];
                        hi_d  = sp[2*dw-1:dw];
                        v_d   = (sp[2*dw-1:dw] != {dw{sp[dw-1]}});
                    end
                end else begin
                    accept = 1'b1;
                end
`else
                accept = 1'b1;
`endif
            end
`ifdef ALU_SIGNED_EN
            S_SGN: begin
                state_d = S_IDLE;
                accept  = 1'b1;
            end
`endif
            default: state_d = S_IDLE;
        endcase

        if (accept && start) begin
            cnt_d = '0;
`ifdef ALU_SIGNED_EN
            sop_d = 1'b0;
`endif
            case (op)
                4'b0000: begin
                    a_d     = AI;
                    acc_d   = {{dw{1'b0}}, BI};
                    state_d = S_MUL;
                end
`ifdef ALU_SIGNED_EN
                4'b1000: begin
                    a_d     = mag(AI);
                    acc_d   = {{dw{1'b0}}, mag(BI)};
                    qneg_d  = AI[dw-1] ^ BI[dw-1];
                    sop_d   = 1'b1;
                    sdiv_d  = 1'b0;
                    state_d = S_MUL;
                end
                4'b0001, 4'b1001: begin
`else
                4'b0001: begin
`endif
                    if (BI == '0) begin
                        out_d   = '1;
                        hi_d    = AI;
                        co_d    = 1'b0;
                        v_d     = 1'b1;
                        dbz_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
`ifdef ALU_SIGNED_EN
                        if (op[3]) begin
                            a_d    = mag(BI);
                            acc_d  = {{dw{1'b0}}, mag(AI)};
                            qneg_d = AI[dw-1] ^ BI[dw-1];
                            rneg_d = AI[dw-1];
                            sop_d  = 1'b1;
                            sdiv_d = 1'b1;
                        end else begin
                            a_d   = BI;
                            acc_d = {{dw{1'b0}}, AI};
                        end
`else
                        a_d   = BI;
                        acc_d = {{dw{1'b0}}, AI};
`endif
                        state_d = S_DIV;
                    end
                end
                default: begin
                    out_d   = sc_out;
                    hi_d    = '0;
                    co_d    = sc_co;
                    v_d     = sc_v;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            acc_q   <= '0;
            out_q   <= '0;
            hi_q    <= '0;
            co_q    <= 1'b0;
            v_q     <= 1'b0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef ALU_SIGNED_EN
            sop_q   <= 1'b0;
            sdiv_q  <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
`endif
        end else if (RDY) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            hi_q    <= hi_d;
            co_q    <= co_d;
            v_q     <= v_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
`ifdef ALU_SIGNED_EN
            sop_q   <= sop_d;
            sdiv_q  <= sdiv_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
`endif
        end
    end

    assign OUT  = out_q;
    assign HI   = hi_q;
    assign CO   = co_q;
    assign V    = v_q;
    assign Z    = (out_q == '0);
    assign N    = out_q[dw-1];
    assign dbz  = dbz_q;
    assign done = done_q;
`ifdef ALU_SIGNED_EN
    assign busy = (state_q == S_MUL) || (state_q == S_DIV) || ((state_q == S_FIN) && sop_q);
`else
    assign busy = (state_q == S_MUL) || (state_q == S_DIV);
`endif

endmodule
